taxi_meter_ctrl: RTL

Top-level trip controller for the taxi meter. It converts the driver buttons into the stop_state/pause_state controls of the distance/low-speed-time datapath. It classifies vehicle speed from wheel pulses into high_speed/low_speed for that datapath. It turns the returned distance and low_time into a registered fare for the display.

---
 rtl/taxi_meter_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/taxi_meter_ctrl.sv
// Taxi meter trip controller: button FSM, wheel-speed classification over
// fixed windows, and registered fare computation for the display.
module taxi_meter_ctrl #(
    parameter int unsigned WINDOW      = 100,
    parameter int unsigned HIGH_THRESH = 5,
    parameter int unsigned BASE_FARE   = 130,
    parameter int unsigned BASE_DIST   = 3000,
    parameter int unsigned KM_FARE     = 23,
    parameter int unsigned LOW_FARE    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic        end_btn,
    input  logic        wheel_clk,
    input  logic [16:0] distance,
    input  logic [16:0] low_time,
    output logic        stop_state,
    output logic        pause_state,
    output logic        high_speed,
    output logic        low_speed,
    output logic [15:0] fare,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_PAUSE   = 2'b10,
        S_ILLEGAL = 2'b11
    } state_t;

    localparam int unsigned WW = $clog2(WINDOW);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

    state_t      state_q, state_d;
    logic        stop_q, pause_q;
    logic        sync1_q, sync2_q, sync3_q, wheel_edge_q;
    logic [WW-1:0] win_q;
    logic [7:0]  edge_cnt_q, edge_sum;
    logic        high_q, low_q;
    logic [15:0] fare_q, fare_sat;
    logic [31:0] dist32, over_m, extra_km, fare_full;

    // Next trip state; end beats pause beats start, illegal code recovers to idle
    always_comb begin
        state_d = S_IDLE;
        unique case (state_q)
            S_IDLE:  state_d = start_btn ? S_RUN : S_IDLE;
            S_RUN:   state_d = end_btn ? S_IDLE : (pause_btn ? S_PAUSE : S_RUN);
            S_PAUSE: state_d = end_btn ? S_IDLE : (pause_btn ? S_RUN : S_PAUSE);
            default: state_d = S_IDLE;
        endcase
    end

    // Trip FSM with datapath controls registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stop_q  <= 1'b1;
            pause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= (state_d == S_IDLE);
            pause_q <= (state_d == S_PAUSE);
        end
    end

    // Wheel pulse synchroniser and registered rising-edge strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync3_q      <= 1'b0;
            wheel_edge_q <= 1'b0;
        end else begin
            sync1_q      <= wheel_clk;
            sync2_q      <= sync1_q;
            sync3_q      <= sync2_q;
            wheel_edge_q <= sync2_q & ~sync3_q;
        end
    end

    // Edge count including the current strobe, saturating at 255
    assign edge_sum = (edge_cnt_q == 8'hFF) ? 8'hFF : edge_cnt_q + {7'b0, wheel_edge_q};

    // Speed window: only counts while staying in RUN; entering or leaving RUN clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q      <= '0;
            edge_cnt_q <= '0;
            high_q     <= 1'b0;
            low_q      <= 1'b0;
        end else if (state_d != S_RUN || state_q != S_RUN) begin
            win_q      <= '0;
            edge_cnt_q <= '0;
            high_q     <= 1'b0;
            low_q      <= 1'b0;
        end else if (win_q == WIN_LAST) begin
            win_q      <= '0;
            edge_cnt_q <= '0;
            high_q     <= (edge_sum >= 8'(HIGH_THRESH));
            low_q      <= (edge_sum <  8'(HIGH_THRESH));
        end else begin
            win_q      <= win_q + WW'(1);
            edge_cnt_q <= edge_sum;
        end
    end

    // Fare from distance and low-speed time, 32-bit then saturated to 16 bits
    always_comb begin
        dist32    = {15'b0, distance};
        over_m    = (dist32 > BASE_DIST) ? dist32 - BASE_DIST : 32'd0;
        extra_km  = (over_m + 32'd999) / 32'd1000;
        fare_full = BASE_FARE + extra_km * KM_FARE + {15'b0, low_time} * LOW_FARE;
        fare_sat  = (|fare_full[31:16]) ? 16'hFFFF : fare_full[15:0];
    end

    // Fare register: flag-fall on trip start, tracks inputs mid-trip, holds in idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fare_q <= '0;
        end else if (state_q == S_IDLE && state_d == S_RUN) begin
            fare_q <= 16'(BASE_FARE);
        end else if (state_q == S_RUN || state_q == S_PAUSE) begin
            fare_q <= fare_sat;
        end
    end

    assign stop_state  = stop_q;
    assign pause_state = pause_q;
    assign high_speed  = high_q;
    assign low_speed   = low_q;
    assign fare        = fare_q;
    assign state       = state_q;

endmodule
